// File: rtl/cpu_controller.sv
// cpu_controller
// Multi-cycle control unit for a small register-file/ALU datapath.
// It fetches 16-bit instructions from an async-read ROM into the IR,
// decodes them in a Moore FSM and drives every datapath control line.
//
// Handshake/timing contract: there is no valid/ready flow control.
// IM_rdata must be valid in the same cycle that PC_addr is presented.
// Data memory reads take one cycle, which is why LOAD uses two states.
// LOAD_A presents the address, and LOAD_B writes the returned data into the RF.
// Every control output is a pure function of (state, IR).
module cpu_controller #(
  parameter int PC_W      = 7,
  parameter int RF_ADDR_W = 5,
  parameter int D_ADDR_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          IM_rdata,
  output logic [PC_W-1:0]      PC_addr,
  output logic [15:0]          IR_out,
  output logic [3:0]           state_out,
  output logic [D_ADDR_W-1:0]  D_addr,
  output logic                 D_wr,
  output logic                 RF_s,
  output logic                 RF_W_en,
  output logic [RF_ADDR_W-1:0] RF_W_addr,
  output logic [RF_ADDR_W-1:0] RF_Ra_addr,
  output logic [RF_ADDR_W-1:0] RF_Rb_addr,
  output logic [2:0]           ALU_sel,
  output logic                 halted
);

  // FSM state encodings, which are visible on state_out for debug.
  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_NOOP   = 4'd3;
  localparam logic [3:0] S_LOAD_A = 4'd4;
  localparam logic [3:0] S_LOAD_B = 4'd5;
  localparam logic [3:0] S_STORE  = 4'd6;
  localparam logic [3:0] S_ADD    = 4'd7;
  localparam logic [3:0] S_SUB    = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;

  // Opcodes held in IR[15:12]. Opcodes 0110 through 1111 decode as NOOP.
  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  logic [3:0]      state;
  logic [3:0]      state_next;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [3:0]      op;

  // Instruction fields, zero-extended or resized to the port widths.
  logic [RF_ADDR_W-1:0] f_ra;
  logic [RF_ADDR_W-1:0] f_rb;
  logic [RF_ADDR_W-1:0] f_rd;
  logic [D_ADDR_W-1:0]  f_store_addr;
  logic [D_ADDR_W-1:0]  f_load_addr;

  assign op           = ir[15:12];
  assign f_ra         = RF_ADDR_W'(ir[11:8]);
  assign f_rb         = RF_ADDR_W'(ir[7:4]);
  assign f_rd         = RF_ADDR_W'(ir[3:0]);
  assign f_store_addr = D_ADDR_W'(ir[7:0]);
  assign f_load_addr  = D_ADDR_W'(ir[11:4]);

  assign PC_addr   = pc;
  assign IR_out    = ir;
  assign state_out = state;

  // Next-state logic. Any undefined encoding falls back to INIT.
  always_comb begin
    state_next = S_INIT;
    case (state)
      S_INIT:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_STORE: state_next = S_STORE;
          OP_LOAD:  state_next = S_LOAD_A;
          OP_ADD:   state_next = S_ADD;
          OP_SUB:   state_next = S_SUB;
          OP_HALT:  state_next = S_HALT;
          default:  state_next = S_NOOP;
        endcase
      end
      S_NOOP:   state_next = S_FETCH;
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B: state_next = S_FETCH;
      S_STORE:  state_next = S_FETCH;
      S_ADD:    state_next = S_FETCH;
      S_SUB:    state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_INIT;
    endcase
  end

  // State register, which is cleared immediately by an asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // PC and IR only change in FETCH, so they stay frozen in HALT.
  // The PC wraps naturally at 2^PC_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
    end else if (state == S_FETCH) begin
      ir <= IM_rdata;
      pc <= pc + PC_W'(1);
    end
  end

  // Moore output decode. Every control defaults to 0 and is raised only in its state.
  always_comb begin
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_sel    = ALU_PASS;
    halted     = 1'b0;
    case (state)
      S_DECODE: begin
        RF_Ra_addr = f_ra;
        RF_Rb_addr = f_rb;
      end
      S_STORE: begin
        D_addr     = f_store_addr;
        RF_Ra_addr = f_ra;
        D_wr       = 1'b1;
      end
      S_LOAD_A: begin
        D_addr    = f_load_addr;
        RF_s      = 1'b1;
        RF_W_addr = f_rd;
      end
      S_LOAD_B: begin
        D_addr    = f_load_addr;
        RF_s      = 1'b1;
        RF_W_addr = f_rd;
        RF_W_en   = 1'b1;
      end
      S_ADD: begin
        RF_Ra_addr = f_ra;
        RF_Rb_addr = f_rb;
        RF_W_addr  = f_rd;
        ALU_sel    = ALU_ADD;
        RF_W_en    = 1'b1;
      end
      S_SUB: begin
        RF_Ra_addr = f_ra;
        RF_Rb_addr = f_rb;
        RF_W_addr  = f_rd;
        ALU_sel    = ALU_SUB;
        RF_W_en    = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller.
// The instruction ROM is modelled as an array inside the bench.
// Outputs are sampled on the falling edge.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic [15:0] im_rdata;
  logic [6:0]  pc_addr;
  logic [15:0] ir_out;
  logic [3:0]  state_out;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic        rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [4:0]  rf_ra_addr;
  logic [4:0]  rf_rb_addr;
  logic [2:0]  alu_sel;
  logic        halted;

  logic [15:0] rom [0:127];

  int n_checks = 0;
  int n_fail   = 0;

  cpu_controller dut (
    .clk        (clk),
    .reset      (reset),
    .IM_rdata   (im_rdata),
    .PC_addr    (pc_addr),
    .IR_out     (ir_out),
    .state_out  (state_out),
    .D_addr     (d_addr),
    .D_wr       (d_wr),
    .RF_s       (rf_s),
    .RF_W_en    (rf_w_en),
    .RF_W_addr  (rf_w_addr),
    .RF_Ra_addr (rf_ra_addr),
    .RF_Rb_addr (rf_rb_addr),
    .ALU_sel    (alu_sel),
    .halted     (halted)
  );

  assign im_rdata = rom[pc_addr];

  // Clock generation. Rising edges occur at 5, 15, 25 and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advances to the next falling edge, one cycle after the previous sample point.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 128; i++) rom[i] = w;
  endtask

  // Holds reset for two cycles and releases it on a falling edge.
  // The controller is left in INIT at the sample point.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wen"}, 32'(rf_w_en), 0);
    check({tag, "_dwr"}, 32'(d_wr), 0);
  endtask

  initial begin
    reset = 1'b1;
    fill_rom(16'h0000);

    // Test 1: ADD R3 = R1 + R2.
    rom[0] = 16'h3123;
    do_reset();
    check("rst_state", 32'(state_out), 0);
    check("rst_pc", 32'(pc_addr), 0);
    check("rst_ir", 32'(ir_out), 0);
    check("rst_alu", 32'(alu_sel), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_daddr", 32'(d_addr), 0);
    check_idle("rst");
    step(); check("add_fetch_state", 32'(state_out), 1);
    step(); check("add_dec_state", 32'(state_out), 2);
    check("add_dec_pc", 32'(pc_addr), 1);
    check("add_dec_ir", 32'(ir_out), 32'h3123);
    check("add_dec_ra", 32'(rf_ra_addr), 1);
    check("add_dec_rb", 32'(rf_rb_addr), 2);
    check_idle("add_dec");
    step(); check("add_state", 32'(state_out), 7);
    check("add_ra", 32'(rf_ra_addr), 1);
    check("add_rb", 32'(rf_rb_addr), 2);
    check("add_wa", 32'(rf_w_addr), 3);
    check("add_alu", 32'(alu_sel), 1);
    check("add_wen", 32'(rf_w_en), 1);
    check("add_rfs", 32'(rf_s), 0);
    check("add_dwr", 32'(d_wr), 0);
    step(); check("add_next_state", 32'(state_out), 1);
    check_idle("add_next");

    // SUB R9 = R4 - R6. This instruction sits at ROM[1].
    rom[1] = 16'h4469;
    step(); step(); check("sub_state", 32'(state_out), 8);
    check("sub_alu", 32'(alu_sel), 2);
    check("sub_wa", 32'(rf_w_addr), 9);
    check("sub_ra", 32'(rf_ra_addr), 4);
    check("sub_rb", 32'(rf_rb_addr), 6);
    check("sub_wen", 32'(rf_w_en), 1);

    // Test 2: LOAD R5 <- D[0x0A].
    fill_rom(16'h0000);
    rom[0] = 16'h20A5;
    do_reset();
    step(); step();
    step(); check("lda_state", 32'(state_out), 4);
    check("lda_daddr", 32'(d_addr), 32'h0A);
    check("lda_rfs", 32'(rf_s), 1);
    check("lda_wa", 32'(rf_w_addr), 5);
    check("lda_wen", 32'(rf_w_en), 0);
    check("lda_dwr", 32'(d_wr), 0);
    step(); check("ldb_state", 32'(state_out), 5);
    check("ldb_daddr", 32'(d_addr), 32'h0A);
    check("ldb_rfs", 32'(rf_s), 1);
    check("ldb_wa", 32'(rf_w_addr), 5);
    check("ldb_wen", 32'(rf_w_en), 1);
    check("ldb_dwr", 32'(d_wr), 0);
    step(); check("ld_next_state", 32'(state_out), 1);
    check_idle("ld_next");

    // Test 3: STORE D[0x44] <- R7.
    fill_rom(16'h0000);
    rom[0] = 16'h1744;
    do_reset();
    step(); step();
    check("st_dec_dwr", 32'(d_wr), 0);
    step(); check("st_state", 32'(state_out), 6);
    check("st_dwr", 32'(d_wr), 1);
    check("st_daddr", 32'(d_addr), 32'h44);
    check("st_ra", 32'(rf_ra_addr), 7);
    check("st_wen", 32'(rf_w_en), 0);
    step(); check("st_next_dwr", 32'(d_wr), 0);
    check("st_next_state", 32'(state_out), 1);

    // Test 4: NOOP, then an illegal op treated as NOOP, then HALT.
    fill_rom(16'h0000);
    rom[1] = 16'hF000;
    rom[2] = 16'h5000;
    do_reset();
    step(); step(); step(); check("noop_state", 32'(state_out), 3);
    check_idle("noop");
    step(); step(); step(); check("illegal_state", 32'(state_out), 3);
    check("illegal_ir", 32'(ir_out), 32'hF000);
    check_idle("illegal");
    step(); step(); step(); check("halt_state", 32'(state_out), 9);
    for (int i = 0; i < 20; i++) begin
      check("halt_flag", 32'(halted), 1);
      check("halt_pc", 32'(pc_addr), 3);
      check("halt_ir", 32'(ir_out), 32'h5000);
      check_idle("halt");
      step();
    end

    // Test 5: a ROM full of NOOPs. The PC wraps from 7'h7F to 0 with no enable activity.
    fill_rom(16'h0000);
    do_reset();
    step();
    for (int k = 0; k < 130; k++) begin
      check("wrap_fetch_state", 32'(state_out), 1);
      check("wrap_pc", 32'(pc_addr), 32'(k % 128));
      check_idle("wrap");
      for (int j = 0; j < 3; j++) begin
        if (j != 0) check_idle("wrap_mid");
        step();
      end
    end

    // Test 6: an asynchronous reset in the middle of LOAD_B.
    fill_rom(16'h0000);
    rom[0] = 16'h20A5;
    do_reset();
    step(); step(); step(); step();
    check("arst_pre_state", 32'(state_out), 5);
    check("arst_pre_wen", 32'(rf_w_en), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_wen", 32'(rf_w_en), 0);
    check("arst_state", 32'(state_out), 0);
    check("arst_pc", 32'(pc_addr), 0);
    check("arst_ir", 32'(ir_out), 0);
    #1 reset = 1'b0;
    step(); check("arst_fetch_state", 32'(state_out), 1);
    check("arst_fetch_pc", 32'(pc_addr), 0);
    step(); check("arst_dec_ir", 32'(ir_out), 32'h20A5);
    check("arst_dec_pc", 32'(pc_addr), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
